// File: rtl/io_debounce.sv
// io_debounce: input conditioner for asynchronous pad signals (buttons, DIP switches).
// Each bit is synchronized by two flops, debounced by a stability counter, and
// presented as a clean level. Optional rise/fall/change pulses are compiled in
// when IO_DEBOUNCE_EDGE_EN is defined. Otherwise they are tied to 0.
//
// Parameters:
//   SW - number of input bits
//   DS - idle level and reset value of the synchronizer and output stages
//   CW - debounce counter width
//   DB - stable cycles required before out changes (1 <= DB <= 2**CW-1)
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   in   - raw pad levels, asynchronous to clk
//   out  - debounced levels
//   rise - one-cycle pulse per bit on an out 0->1 transition
//   fall - one-cycle pulse per bit on an out 1->0 transition
//   chg  - registered OR of all rise|fall pulses
module io_debounce #(
  parameter int unsigned SW = 1,
  parameter logic        DS = 1'b0,
  parameter int unsigned CW = 16,
  parameter int unsigned DB = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] in,
  output logic [SW-1:0] out,
  output logic [SW-1:0] rise,
  output logic [SW-1:0] fall,
  output logic          chg
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);

  logic [SW-1:0] s0;
  logic [SW-1:0] s1;
  logic [SW-1:0] out_q;
  logic [SW-1:0] out_n;
  logic [CW-1:0] cnt   [SW];
  logic [CW-1:0] cnt_n [SW];

  // Two-flop synchronizer with nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= {SW{DS}};
      s1 <= {SW{DS}};
    end else begin
      s0 <= in;
      s1 <= s0;
    end
  end

  // A bit counts while s1 differs from out, and it restarts whenever the two agree.
  // out follows s1 once the difference has been seen on DB consecutive edges.
  always_comb begin
    out_n = out_q;
    for (int unsigned i = 0; i < SW; i++) begin
      cnt_n[i] = '0;
      if (s1[i] != out_q[i]) begin
        if (cnt[i] == CNT_LAST) begin
          out_n[i] = s1[i];
        end else begin
          cnt_n[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= {SW{DS}};
      for (int unsigned i = 0; i < SW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      out_q <= out_n;
      for (int unsigned i = 0; i < SW; i++) begin
        cnt[i] <= cnt_n[i];
      end
    end
  end

  assign out = out_q;

`ifdef IO_DEBOUNCE_EDGE_EN
  logic [SW-1:0] rise_n;
  logic [SW-1:0] fall_n;
  logic [SW-1:0] rise_q;
  logic [SW-1:0] fall_q;
  logic          chg_q;

  // Pulses come from the same next-state term as out, so they line up with the new level.
  always_comb begin
    rise_n = out_n & ~out_q;
    fall_n = ~out_n & out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      rise_q <= rise_n;
      fall_q <= fall_n;
      chg_q  <= |(rise_n | fall_n);
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
  assign chg  = chg_q;
`else
  assign rise = '0;
  assign fall = '0;
  assign chg  = 1'b0;
`endif

endmodule

// File: tb/tb_io_debounce.sv
// tb_io_debounce: directed tests for io_debounce with SW=4, DS=0, DB=4.
// The expected values for rise, fall and chg depend on IO_DEBOUNCE_EDGE_EN.
module tb_io_debounce;

`ifdef IO_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in  = 4'h0;
  logic [3:0] out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       chg;

  int vectors = 0;
  int miscompares = 0;

  io_debounce #(.SW(4), .DS(1'b0), .CW(8), .DB(4)) dut (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .out (out),
    .rise(rise),
    .fall(fall),
    .chg (chg)
  );

  always #5 clk = ~clk;

  // Pack expected {out, rise, fall, chg}. When the edge feature is absent, the pulses are 0.
  function automatic logic [12:0] pk(input logic [3:0] o, input logic [3:0] r,
                                     input logic [3:0] f, input logic c);
    return {o, r & {4{EDGE}}, f & {4{EDGE}}, c & EDGE};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] e;
    rst = 1'b1;
    in  = 4'hF;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = pk(4'h0, 4'h0, 4'h0, 1'b0);
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = (k >= 5) ? pk(4'hF, (k == 5) ? 4'hF : 4'h0, 4'h0, k == 5)
                   : pk(4'h0, 4'h0, 4'h0, 1'b0);
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL reset_release k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
  endtask

  task automatic test_latency_fall_all();
    logic [12:0] e;
    in = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = (k >= 5) ? pk(4'h0, 4'h0, (k == 5) ? 4'hF : 4'h0, k == 5)
                   : pk(4'hF, 4'h0, 4'h0, 1'b0);
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL latency_fall_all k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
  endtask

  task automatic test_latency_bit0();
    logic [12:0] e;
    in = 4'h1;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = pk((k >= 5) ? 4'h1 : 4'h0, (k == 5) ? 4'h1 : 4'h0, 4'h0, k == 5);
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL latency_rise k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
    in = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick();
      e = pk((k >= 5) ? 4'h0 : 4'h1, 4'h0, (k == 5) ? 4'h1 : 4'h0, k == 5);
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL latency_fall k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
  endtask

  task automatic test_glitch();
    logic [12:0] e;
    e = pk(4'h0, 4'h0, 4'h0, 1'b0);
    for (int k = 0; k < 14; k++) begin
      in = (k < 3) ? 4'h1 : 4'h0;
      tick();
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL glitch k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
  endtask

  task automatic test_bounce();
    logic [12:0] e;
    int pulses;
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      in = (t % 2 == 0) ? 4'h1 : 4'h0;
      tick();
      e = pk(4'h0, 4'h0, 4'h0, 1'b0);
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL bounce_toggle t=%0d got=%h exp=%h", t, {out, rise, fall, chg}, e);
      end
    end
    in = 4'h1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rise[0]) pulses++;
      e = pk((k >= 5) ? 4'h1 : 4'h0, (k == 5) ? 4'h1 : 4'h0, 4'h0, k == 5);
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL bounce_settle k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
    vectors++;
    if (pulses !== (EDGE ? 1 : 0)) begin
      miscompares++;
      $display("FAIL bounce_pulse_count got=%0d exp=%0d", pulses, EDGE ? 1 : 0);
    end
    in = 4'h0;
    repeat (8) tick();
  endtask

  task automatic test_independence();
    logic [12:0] e;
    logic [3:0] eo;
    logic [3:0] er;
    in = 4'h2;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 1) in = 4'h6;
      eo = {1'b0, k >= 7, k >= 5, 1'b0};
      er = {1'b0, k == 7, k == 5, 1'b0};
      e  = pk(eo, er, 4'h0, (k == 5) || (k == 7));
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL independence k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [12:0] e;
    in = 4'h0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    e = pk(4'h0, 4'h0, 4'h0, 1'b0);
    vectors++;
    if ({out, rise, fall, chg} !== e) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=%h", {out, rise, fall, chg}, e);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if ({out, rise, fall, chg} !== e) begin
        miscompares++;
        $display("FAIL reset_idle k=%0d got=%h exp=%h", k, {out, rise, fall, chg}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency_fall_all();
    test_latency_bit0();
    test_glitch();
    test_bounce();
    test_independence();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
